// File: rtl/spi_status_framer_if.sv
// Bundle between the status framer and its neighbours.
//   i_status      live status word (system clock domain)
//   i_cs          SPI chip select, active low, asynchronous
//   o_data        published frame {seq, payload, crc}
//   o_frame_valid one-cycle pulse when o_data is updated
//   o_drop_count  snapshots discarded because CS was active at commit
//   o_read_count  completed SPI transactions
// modport slave is the framer side; modport master is the environment side.
interface spi_status_framer_if #(
  parameter int unsigned PAYLOAD_WIDTH = 64
);
  logic [PAYLOAD_WIDTH-1:0]  i_status;
  logic                      i_cs;
  logic [PAYLOAD_WIDTH+15:0] o_data;
  logic                      o_frame_valid;
  logic [15:0]               o_drop_count;
  logic [15:0]               o_read_count;

  modport master (
    output i_status,
    output i_cs,
    input  o_data,
    input  o_frame_valid,
    input  o_drop_count,
    input  o_read_count
  );

  modport slave (
    input  i_status,
    input  i_cs,
    output o_data,
    output o_frame_valid,
    output o_drop_count,
    output o_read_count
  );
endinterface

// File: rtl/spi_status_framer.sv
// Periodic status framer feeding a bulk SPI status slave.
// Every UPDATE_PERIOD clocks it snapshots the status word, prefixes an 8-bit
// sequence number, folds seq+payload into a CRC-8/SMBUS one byte per clock and
// publishes {seq, payload, crc} on o_data, but only if CS is idle at commit so
// the published frame never changes under an active SPI read.
// Ports:
//   i_clk  system clock
//   i_rst  asynchronous active-high reset
//   bus    spi_status_framer_if.slave (status in, CS in, frame/counters out)
module spi_status_framer #(
  parameter int unsigned PAYLOAD_WIDTH = 64,
  parameter int unsigned UPDATE_PERIOD = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  spi_status_framer_if.slave   bus
);

  localparam int unsigned NB   = PAYLOAD_WIDTH / 8 + 1;  // bytes under the CRC
  localparam int unsigned MsgW = NB * 8;
  localparam int unsigned CntW = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam int unsigned IdxW = $clog2(NB);

  typedef enum logic [1:0] {StIdle, StCapture, StCrc, StCommit} state_e;

  // One full byte of CRC-8, poly 0x07, MSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q;
  logic                      tick;
  logic                      cs_meta_q, cs_s_q, cs_d_q;
  logic                      cs_idle;
  logic [7:0]                seq_q, seq_d;
  logic [7:0]                work_seq_q, work_seq_d;
  logic [PAYLOAD_WIDTH-1:0]  work_payload_q, work_payload_d;
  // Copy of {seq, payload} shifted left one byte per CRC cycle; top byte is next.
  logic [MsgW-1:0]           msg_sh_q, msg_sh_d;
  logic [7:0]                crc_q, crc_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  logic [PAYLOAD_WIDTH+15:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic [15:0]               drop_q, drop_d;
  logic [15:0]               read_q;

  // CS synchronizer plus edge-detect flop; idle (high) out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cs_meta_q <= 1'b1;
      cs_s_q    <= 1'b1;
      cs_d_q    <= 1'b1;
      read_q    <= '0;
    end else begin
      cs_meta_q <= bus.i_cs;
      cs_s_q    <= cs_meta_q;
      cs_d_q    <= cs_s_q;
      if (cs_s_q && !cs_d_q) begin
        read_q <= read_q + 16'd1;
      end
    end
  end

  assign cs_idle = cs_s_q;

  // Free-running period counter; never stalls regardless of FSM state.
  assign tick = (cnt_q == CntW'(UPDATE_PERIOD - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  always_comb begin
    state_d        = state_q;
    seq_d          = seq_q;
    work_seq_d     = work_seq_q;
    work_payload_d = work_payload_q;
    msg_sh_d       = msg_sh_q;
    crc_d          = crc_q;
    idx_d          = idx_q;
    data_d         = data_q;
    valid_d        = 1'b0;
    drop_d         = drop_q;
    unique case (state_q)
      StIdle: begin
        // A tick under active CS is simply skipped, not a drop.
        if (tick && cs_idle) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        work_seq_d     = seq_q + 8'd1;
        work_payload_d = bus.i_status;
        msg_sh_d       = {seq_q + 8'd1, bus.i_status};
        crc_d          = '0;
        idx_d          = '0;
        state_d        = StCrc;
      end
      StCrc: begin
        crc_d    = crc8_byte(crc_q, msg_sh_q[MsgW-1 -: 8]);
        msg_sh_d = msg_sh_q << 8;
        idx_d    = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NB - 1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        // CS activity during capture/CRC is irrelevant; only this cycle decides.
        if (cs_idle) begin
          data_d  = {work_seq_q, work_payload_q, crc_q};
          seq_d   = work_seq_q;
          valid_d = 1'b1;
        end else begin
          drop_d = drop_q + 16'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= StIdle;
      seq_q          <= '0;
      work_seq_q     <= '0;
      work_payload_q <= '0;
      msg_sh_q       <= '0;
      crc_q          <= '0;
      idx_q          <= '0;
      data_q         <= '0;
      valid_q        <= 1'b0;
      drop_q         <= '0;
    end else begin
      state_q        <= state_d;
      seq_q          <= seq_d;
      work_seq_q     <= work_seq_d;
      work_payload_q <= work_payload_d;
      msg_sh_q       <= msg_sh_d;
      crc_q          <= crc_d;
      idx_q          <= idx_d;
      data_q         <= data_d;
      valid_q        <= valid_d;
      drop_q         <= drop_d;
    end
  end

  assign bus.o_data        = data_q;
  assign bus.o_frame_valid = valid_q;
  assign bus.o_drop_count  = drop_q;
  assign bus.o_read_count  = read_q;

endmodule
